// File: rtl/link_pkg.sv
// Shared constants and FSM state type for the link transmit controller.
package link_pkg;

   localparam int FLIT_W     = 32;
   localparam int HALF_W     = 16;
   localparam int INV_LO_BIT = 15;
   localparam int INV_HI_BIT = 31;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/link_inv_enc.sv
// Two-half coupling-invert encoder: each 16-bit half carries 15 payload bits
// plus an invert flag in its MSB, chosen against the previous word on the wires.
module link_inv_enc
   import link_pkg::*;
(
   input  logic [FLIT_W-1:0] x,
   input  logic [FLIT_W-1:0] y,
   output logic [FLIT_W-1:0] z
);

   function automatic logic [3:0] pop15(input logic [HALF_W-2:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < HALF_W - 1; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

   // The plain candidate {0, x[14:0]} is judged over all 15 adjacent pairs of
   // the half, flag wire included. Inverting flips every wire, so opposite
   // toggles (T2) become stable-differing pairs (T4stst) and vice versa.
   function automatic logic [HALF_W-1:0] enc_half(input logic [HALF_W-1:0] xh,
                                                  input logic [HALF_W-1:0] yh);
      logic [HALF_W-1:0] plain;
      logic [HALF_W-1:0] tog;
      logic [HALF_W-2:0] diff;
      logic [HALF_W-2:0] t2;
      logic [HALF_W-2:0] t4stst;
      plain  = {1'b0, xh[HALF_W-2:0]};
      tog    = plain ^ yh;
      diff   = plain[HALF_W-2:0] ^ plain[HALF_W-1:1];
      t2     = tog[HALF_W-2:0] & tog[HALF_W-1:1] & diff;
      t4stst = ~tog[HALF_W-2:0] & ~tog[HALF_W-1:1] & diff;
      if (pop15(t2) > pop15(t4stst)) return {1'b1, ~xh[HALF_W-2:0]};
      return plain;
   endfunction

   assign z = {enc_half(x[FLIT_W-1:HALF_W], y[FLIT_W-1:HALF_W]),
               enc_half(x[HALF_W-1:0],      y[HALF_W-1:0])};

endmodule

// File: rtl/link_rr_arb.sv
// Two-requester round-robin arbiter; the priority pointer moves past the
// releasing owner on each release pulse.
module link_rr_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       rel,
   input  logic       owner,
   output logic [1:0] gnt
);

   logic ptr;

   // NOTE: state flops use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   ptr <= 1'b0;
      else if (rel) ptr <= ~owner;
   end

   // NOTE: gnt gets a default before the branches so no latch is inferred.
   always_comb begin
      gnt = 2'b00;
      if (req[ptr])       gnt[ptr]  = 1'b1;
      else if (req[~ptr]) gnt[~ptr] = 1'b1;
   end

endmodule

// File: rtl/link_tx_ctrl.sv
// Packet-locked two-requester link transmitter with coupling-invert encoding.
// Optional LINK_TX_STATS_EN adds a saturating inv_count of invert flags sent.
module link_tx_ctrl
   import link_pkg::*;
#(
   parameter int MAX_PKT = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   input  logic [63:0] req_data,
   input  logic [1:0]  req_last,
   output logic [1:0]  req_ready,
   output logic [31:0] link_data,
   output logic        link_valid,
   input  logic        link_ready,
   output logic        pkt_err
`ifdef LINK_TX_STATS_EN
   ,
   output logic [15:0] inv_count
`endif
);

   state_t            state;
   logic              owner;
   logic [7:0]        flit_cnt;
   logic [1:0]        gnt;
   logic [FLIT_W-1:0] flit_sel;
   logic [FLIT_W-1:0] enc_word;
   logic              can_send;
   logic              accept;
   logic              last_sel;
   logic              cnt_hit;
   logic              release_pkt;

   assign can_send    = (state == ST_BUSY) && (!link_valid || link_ready);
   assign req_ready   = can_send ? (owner ? 2'b10 : 2'b01) : 2'b00;
   assign flit_sel    = owner ? req_data[63:32] : req_data[31:0];
   assign last_sel    = req_last[owner];
   assign accept      = |(req_ready & req_valid);
   assign cnt_hit     = (flit_cnt == 8'(MAX_PKT - 1));
   assign release_pkt = accept && (last_sel || cnt_hit);

   link_rr_arb u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_valid),
      .rel   (release_pkt),
      .owner (owner),
      .gnt   (gnt)
   );

   // link_data is the encoder's reference, so it is kept after the sink takes it.
   link_inv_enc u_enc (
      .x (flit_sel),
      .y (link_data),
      .z (enc_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         owner      <= 1'b0;
         flit_cnt   <= 8'd0;
         link_data  <= '0;
         link_valid <= 1'b0;
         pkt_err    <= 1'b0;
      end else begin
         if (accept) begin
            link_data  <= enc_word;
            link_valid <= 1'b1;
         end else if (link_ready) begin
            link_valid <= 1'b0;
         end
         case (state)
            ST_IDLE: begin
               if (|gnt) begin
                  owner    <= gnt[1];
                  flit_cnt <= 8'd0;
                  state    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (accept) begin
                  flit_cnt <= flit_cnt + 8'd1;
                  if (release_pkt)          state   <= ST_IDLE;
                  if (!last_sel && cnt_hit) pkt_err <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef LINK_TX_STATS_EN
   logic [16:0] inv_sum;

   assign inv_sum = {1'b0, inv_count} + 17'(enc_word[INV_HI_BIT])
                                      + 17'(enc_word[INV_LO_BIT]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      inv_count <= 16'd0;
      else if (accept) inv_count <= inv_sum[16] ? 16'hFFFF : inv_sum[15:0];
   end
`endif

endmodule

// File: doc/link_tx_ctrl.md
LINK_TX_CTRL -- requirements
Module: link_tx_ctrl

Interface
REQ-001 SHALL have parameter MAX_PKT, default 8: maximum flits per packet before a forced grant release (range 1..255).
REQ-002 SHALL have port clk  input  1  clock; all flops are rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid  input  2  per-requester flit valid.
REQ-005 SHALL have port req_data  input  64  flits; requester i occupies [32*i+31:32*i]; bits 15 and 31 of each flit are reserved and ignored.
REQ-006 SHALL have port req_last  input  2  per-requester last-flit-of-packet marker.
REQ-007 SHALL have port req_ready  output  2  per-requester flit accepted this cycle when valid.
REQ-008 SHALL have port link_data  output  32  encoded flit; bit 15 is the low-half invert flag, bit 31 is the high-half invert flag.
REQ-009 SHALL have port link_valid  output  1  link_data holds a flit.
REQ-010 SHALL have port link_ready  input  1  link sink accepts link_data.
REQ-011 SHALL have port pkt_err  output  1  sticky flag: a packet exceeded MAX_PKT flits.

Function
REQ-012 SHALL implement FSM IDLE/BUSY: IDLE->BUSY when any req_valid is high (grant chosen that cycle); BUSY->IDLE when the granted flit with req_last=1 is accepted, or when the MAX_PKT-th flit of a packet is accepted.
REQ-013 SHALL arbitrate round-robin between packets: the grant is locked for a whole packet; the next grant goes to the other requester if it is valid, otherwise to the same requester.
REQ-014 SHALL assert pkt_err sticky on a forced release; the requester's following flits form a new packet subject to arbitration.
REQ-015 SHALL drive req_ready[i] = BUSY and grant==i and (!link_valid or link_ready); the non-granted requester's req_ready SHALL be 0.
REQ-016 SHALL encode each accepted flit per 16-bit half, using the flit as x and the current link_data register (previous transmitted word) as y: invert bits [14:0] when the count of T2 couplings exceeds the count of T4stst couplings over the 15 adjacent bit pairs; write the invert flag into bit 15. The same rule SHALL apply to bits [30:16] with the flag in bit 31.
REQ-017 SHALL register the encoded flit into link_data on acceptance; latency SHALL be 1 cycle from req acceptance to link_valid.
REQ-018 SHALL hold link_data and link_valid stable while link_valid=1 and link_ready=0.
REQ-019 SHALL clear link_valid after link_ready=1 when no new flit is accepted in that cycle; link_data SHALL retain its last value so the next encoding references the last word on the wires.
REQ-020 SHALL allow a simultaneous link_ready=1 and a new acceptance to produce back-to-back flits with no bubble.
REQ-021 SHALL count flits per packet in an 8-bit counter, cleared at each grant.

Reset
REQ-022 SHALL, on rst_n low, force: state IDLE, grant pointer to requester 0, link_data 0x0000_0000, link_valid 0, req_ready 0, pkt_err 0, flit counter 0.
REQ-023 SHALL abandon any in-progress packet on reset mid-packet, with no partial flit emitted after reset release.

Configuration
REQ-024 SHALL, with LINK_TX_STATS_EN defined, add output inv_count (16 bits, saturating), which increments by the number of invert flags set (0, 1 or 2) in each flit loaded into link_data and resets to 0.
REQ-025 SHALL, without LINK_TX_STATS_EN, have no inv_count port and no counter logic.

Structure
REQ-026 SHALL take from package link_pkg: FLIT_W=32, HALF_W=16, INV_LO_BIT=15, INV_HI_BIT=31, and the FSM state enum.
REQ-027 SHALL place arbitration in sub-module link_rr_arb: 2 requests in, one-hot grant out, pointer advanced on a release pulse.
REQ-028 SHALL instantiate the existing 32-bit two-half invert encoder for the REQ-016 encoding, not re-implement it.

Verification
REQ-029 SHALL cover: reset, then req0 sends one flit 0x0000_0000 with last=1, link_ready=1 -> link_data=0x0000_0000 with link_valid=1 one cycle after acceptance, pkt_err=0.
REQ-030 SHALL cover: both requesters valid with 2-flit packets -> packet order req0, req1, req0, with no interleaving inside a packet.
REQ-031 SHALL cover: link_ready held 0 for 5 cycles with a flit pending -> link_data constant, req_ready=0, then the flit is accepted on link_ready=1.
REQ-032 SHALL cover: req1 streams 9 flits with last=0, MAX_PKT=8 -> release after flit 8, pkt_err=1 and stays 1, flit 9 starts a new packet.
REQ-033 SHALL cover: random 1000 flits versus a reference model of REQ-016 -> bit-exact link_data, with each invert flag matching the T2>T4stst decision against the previous link_data.
REQ-034 SHALL cover: rst_n asserted mid-packet -> all outputs at REQ-022 values within the same cycle, and the first flit after reset is encoded against 0x0000_0000.
